// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 PRGA encryptor; streams length-prefixed PT through the keystream into length-prefixed CT.
// Define ARC4_DROP_EN to discard DROP_N keystream bytes before the first message byte.
module arc4_encrypt
`ifdef ARC4_DROP_EN
#(
   parameter int DROP_N = 256
)
`endif
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic [7:0] ct_addr,
   output logic [7:0] ct_wrdata,
   output logic       ct_wren
);
   typedef enum logic [3:0] {IDLE, LEN_RD, LEN_WR, S_RDI, S_RDJ, SWAP1, SWAP2, PAD_RD, XOR_WR} state_t;
   state_t state;
   logic [7:0] i, j, k, len, si, sj;
`ifdef ARC4_DROP_EN
   logic [15:0] drop;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         i <= '0;
         j <= '0;
         k <= '0;
         len <= '0;
         si <= '0;
         sj <= '0;
`ifdef ARC4_DROP_EN
         drop <= '0;
`endif
      end else
         case (state)
            IDLE:
               if (en) begin
                  state <= LEN_RD;
                  i <= 8'd1;
                  j <= '0;
                  k <= 8'd1;
               end
            LEN_RD: state <= LEN_WR;
            LEN_WR: begin
               len <= pt_rddata;
               state <= pt_rddata == 8'd0 ? IDLE : S_RDI;
`ifdef ARC4_DROP_EN
               drop <= 16'(DROP_N);
`endif
            end
            S_RDI: state <= S_RDJ;
            S_RDJ: begin
               si <= s_rddata;
               j <= j + s_rddata;
               state <= SWAP1;
            end
            SWAP1: begin
               sj <= s_rddata;
               state <= SWAP2;
            end
`ifdef ARC4_DROP_EN
            SWAP2:
               if (drop != 16'd0) begin
                  drop <= drop - 16'd1;
                  i <= i + 8'd1;
                  state <= S_RDI;
               end else
                  state <= PAD_RD;
`else
            SWAP2: state <= PAD_RD;
`endif
            PAD_RD: state <= XOR_WR;
            XOR_WR: begin
               i <= i + 8'd1;
               k <= k + 8'd1;
               state <= k == len ? IDLE : S_RDI;
            end
            default: state <= IDLE;
         endcase
   // the j read address and the ciphertext depend on the same-cycle memory data, so ports decode combinationally
   always_comb begin
      rdy = state == IDLE;
      s_addr = (state == S_RDI || state == SWAP2) ? i :
               state == S_RDJ ? j + s_rddata :
               state == SWAP1 ? j :
               state == PAD_RD ? si + sj : 8'd0;
      s_wrdata = state == SWAP1 ? si : state == SWAP2 ? sj : 8'd0;
      s_wren = state == SWAP1 || state == SWAP2;
      pt_addr = state == PAD_RD ? k : 8'd0;
      ct_wren = state == LEN_WR || state == XOR_WR;
      ct_addr = state == XOR_WR ? k : 8'd0;
      ct_wrdata = state == LEN_WR ? pt_rddata : state == XOR_WR ? pt_rddata ^ s_rddata : 8'd0;
   end
endmodule
